// File: rtl/npu_pkg.sv
// Shared NPU types: feeder FSM state encoding and the signed activation type.
package npu_pkg;

  localparam int ACT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

  typedef logic signed [ACT_WIDTH-1:0] act_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying {valid,data}; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail
);

  if (DEPTH == 0) begin : g_wire
    logic sig_unused;
    assign sig_unused = ^{clk, rst_n, flush};
    assign tail = head;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= head;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign tail = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_row_feeder.sv
// Activation feeder for the PE array: accepts ROWS-wide vectors, skews row r by r cycles,
// and sequences clear/stream/drain for one accumulation pass.
module systolic_row_feeder
  import npu_pkg::*;
#(
  parameter  int ROWS       = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_LEN    = 256,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LEN_W-1:0]           vec_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  output logic [ROWS*DATA_WIDTH-1:0] pe_data,
  output logic [ROWS-1:0]            pe_enable,
  output logic                       pe_clear_acc,
  output logic                       busy,
  output logic                       done,
  output feeder_state_e              dbg_state
);

  localparam int DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_e state, next_state;
  logic [LEN_W-1:0] len_q, accept_cnt, len_sat;
  logic [DRAIN_W-1:0] drain_cnt;
  logic accept, flush, launch;
  logic row_valid;
  logic [ROWS*DATA_WIDTH-1:0] row_data;

  // Handshake: a vector transfers in any cycle where in_valid && in_ready; in_ready depends
  // only on state (high throughout STREAM), never on in_valid.
  assign accept  = in_valid && in_ready;
  assign flush   = abort && (state != IDLE);
  assign launch  = (state == IDLE) && start && !abort;
  assign len_sat = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    pe_clear_acc = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:   if (launch) next_state = CLEAR;
      CLEAR: begin
        pe_clear_acc = 1'b1;
        next_state   = (len_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (accept && (accept_cnt == len_q - LEN_W'(1))) next_state = DRAIN;
      end
      DRAIN:  if (drain_cnt == DRAIN_W'(ROWS - 1)) next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      accept_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      if (launch) begin
        len_q      <= len_sat;
        accept_cnt <= '0;
      end else if (flush) begin
        accept_cnt <= '0;
      end else if ((state == STREAM) && accept) begin
        accept_cnt <= accept_cnt + LEN_W'(1);
      end
      if ((state == DRAIN) && !flush) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                            drain_cnt <= '0;
    end
  end

  // Common input stage; non-accept cycles inject a zeroed bubble so disabled rows read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_valid <= 1'b0;
      row_data  <= '0;
    end else if (flush) begin
      row_valid <= 1'b0;
      row_data  <= '0;
    end else begin
      row_valid <= accept;
      row_data  <= accept ? in_data : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH:0] tail;

    skew_delay_line #(
      .DEPTH(r),
      .WIDTH(DATA_WIDTH + 1)
    ) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .head ({row_valid, row_data[r*DATA_WIDTH +: DATA_WIDTH]}),
      .tail (tail)
    );

    assign pe_enable[r]                        = tail[DATA_WIDTH];
    assign pe_data[r*DATA_WIDTH +: DATA_WIDTH] = tail[DATA_WIDTH-1:0];
  end

endmodule
